// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_arbiter: two-port (CPU=A, DMA=B) arbiter onto one data memory.    |
// | Optional macro DATA_MEM_ARB_FIXED_PRIO_EN: port A wins every tie.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module data_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] WriteData,
    input  logic [DW-1:0] ReadData,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic c_PORT_A = 1'b0;
    localparam logic c_PORT_B = 1'b1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_win;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;
    logic          w_win;
    logic          w_any_req;
    logic          w_access;

    assign w_any_req = a_req | b_req;
    assign w_access  = (r_state == ACCESS);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = a_req ? c_PORT_A : c_PORT_B;
    end
`else
    logic r_last;

    // On a tie the port that did not win last time is served.
    always_comb begin
        w_win = a_req ? c_PORT_A : c_PORT_B;
        if (a_req && b_req) begin
            w_win = ~r_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= c_PORT_B;
        end else if (w_access) begin
            r_last <= r_win;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = r_we ? IDLE : RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_win     <= c_PORT_A;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any_req) begin
                r_win   <= w_win;
                r_we    <= (w_win == c_PORT_A) ? a_we    : b_we;
                r_addr  <= (w_win == c_PORT_A) ? a_addr  : b_addr;
                r_wdata <= (w_win == c_PORT_A) ? a_wdata : b_wdata;
            end
            if (w_access && !r_we) begin
                if (r_win == c_PORT_A) begin
                    r_a_rdata <= ReadData;
                end else begin
                    r_b_rdata <= ReadData;
                end
            end
        end
    end

    // Pulses are suppressed while reset is asserted so an aborted access never reports.
    assign a_gnt     = rst_n & w_access & (r_win == c_PORT_A);
    assign b_gnt     = rst_n & w_access & (r_win == c_PORT_B);
    assign a_rvalid  = rst_n & (r_state == RESP) & (r_win == c_PORT_A);
    assign b_rvalid  = rst_n & (r_state == RESP) & (r_win == c_PORT_B);
    assign MemWrite  = w_access & r_we;
    assign MemRead   = w_access & ~r_we;
    assign Address   = r_addr;
    assign WriteData = r_wdata;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_mem_arbiter: directed vector table plus randomized traffic checked |
// | against a transaction-level model of the arbiter.                         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_data_mem_arbiter;

    localparam int NT = 39;
    localparam int NR = 1500;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        MemRead, MemWrite, busy;
    logic [31:0] Address, WriteData, ReadData;

    int nerr = 0;
    int nchk = 0;

    data_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory fixture: combinational read, write on the clock edge.
    logic [31:0] mem [0:15];
    always @(posedge clk) if (MemWrite) mem[Address[5:2]] <= WriteData;
    assign ReadData = mem[Address[5:2]];

    typedef struct {
        logic        rst_n;
        logic        a_req, a_we;
        logic [31:0] a_addr, a_wdata;
        logic        b_req, b_we;
        logic [31:0] b_addr, b_wdata;
        logic [6:0]  e_flags;   // {a_gnt,b_gnt,a_rvalid,b_rvalid,MemRead,MemWrite,busy}
        logic [31:0] e_addr, e_wd, e_ard, e_brd;
    } vec_t;

    vec_t tbl [0:NT-1];

    function automatic vec_t v(input int rs, input int ar, input int aw, input logic [31:0] aa,
                               input logic [31:0] ad, input int br, input int bw,
                               input logic [31:0] ba, input logic [31:0] bd, input logic [6:0] f,
                               input logic [31:0] ea, input logic [31:0] ewd,
                               input logic [31:0] era, input logic [31:0] erb);
        vec_t r;
        r.rst_n = (rs != 0); r.a_req = (ar != 0); r.a_we = (aw != 0);
        r.a_addr = aa; r.a_wdata = ad;
        r.b_req = (br != 0); r.b_we = (bw != 0); r.b_addr = ba; r.b_wdata = bd;
        r.e_flags = f; r.e_addr = ea; r.e_wd = ewd; r.e_ard = era; r.e_brd = erb;
        return r;
    endfunction

    task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Transaction-level expectations, indexed by cycle of the random phase.
    int          eg  [0:NR+3];
    int          erv [0:NR+3];
    logic        ewe [0:NR+3];
    logic        ebusy [0:NR+3];
    logic [31:0] eaddr [0:NR+3];
    logic [31:0] ewd [0:NR+3];
    logic [31:0] erd [0:NR+3];
    logic [31:0] refmem [0:15];

    localparam logic [31:0] M1 = 32'h1000_0001;
    localparam logic [31:0] M2 = 32'h1000_0002;
    localparam logic [31:0] M3 = 32'h1000_0003;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        int          free_at, prev_w, w;
        logic        twe;
        logic [31:0] tad, twd, last_addr, last_wd, exp_ard, exp_brd;
        logic [6:0]  ef;

        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);

        tbl[0]  = v(0, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h0,  32'h0, 32'h0, 32'h0);
        tbl[1]  = v(1, 1,1,32'h0,DB,          0,0,32'h0,32'h0,   7'b0000000, 32'h0,  32'h0, 32'h0, 32'h0);
        tbl[2]  = v(1, 1,1,32'h0,DB,          0,0,32'h0,32'h0,   7'b1000011, 32'h0,  DB,    32'h0, 32'h0);
        tbl[3]  = v(1, 1,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h0,  32'h0, 32'h0, 32'h0);
        tbl[4]  = v(1, 1,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b1000101, 32'h0,  32'h0, 32'h0, 32'h0);
        tbl[5]  = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0010001, 32'h0,  32'h0, DB,    32'h0);
        tbl[6]  = v(0, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h0,  32'h0, DB,    32'h0);
        tbl[7]  = v(1, 1,0,32'h4,32'h0,       1,0,32'h8,32'h0,   7'b0000000, 32'h0,  32'h0, 32'h0, 32'h0);
        tbl[8]  = v(1, 1,0,32'h4,32'h0,       1,0,32'h8,32'h0,   7'b1000101, 32'h4,  32'h0, 32'h0, 32'h0);
        tbl[9]  = v(1, 0,0,32'h0,32'h0,       1,0,32'h8,32'h0,   7'b0010001, 32'h4,  32'h0, M1,    32'h0);
        tbl[10] = v(1, 0,0,32'h0,32'h0,       1,0,32'h8,32'h0,   7'b0000000, 32'h4,  32'h0, M1,    32'h0);
        tbl[11] = v(1, 0,0,32'h0,32'h0,       1,0,32'h8,32'h0,   7'b0100101, 32'h8,  32'h0, M1,    32'h0);
        tbl[12] = v(1, 1,0,32'hC,32'h0,       1,0,32'h4,32'h0,   7'b0001001, 32'h8,  32'h0, M1,    M2);
        tbl[13] = v(1, 1,0,32'hC,32'h0,       1,0,32'h4,32'h0,   7'b0000000, 32'h8,  32'h0, M1,    M2);
        tbl[14] = v(1, 1,0,32'hC,32'h0,       1,0,32'h4,32'h0,   7'b1000101, 32'hC,  32'h0, M1,    M2);
        tbl[15] = v(1, 0,0,32'h0,32'h0,       1,0,32'h4,32'h0,   7'b0010001, 32'hC,  32'h0, M3,    M2);
        tbl[16] = v(1, 0,0,32'h0,32'h0,       1,0,32'h4,32'h0,   7'b0000000, 32'hC,  32'h0, M3,    M2);
        tbl[17] = v(1, 0,0,32'h0,32'h0,       1,0,32'h4,32'h0,   7'b0100101, 32'h4,  32'h0, M3,    M2);
        tbl[18] = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0001001, 32'h4,  32'h0, M3,    M1);
        tbl[19] = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h4,  32'h0, M3,    M1);
        tbl[20] = v(1, 0,0,32'h0,32'h0,       1,1,32'h10,32'h11, 7'b0000000, 32'h4,  32'h0, M3,    M1);
        tbl[21] = v(1, 0,0,32'h0,32'h0,       1,1,32'h10,32'h11, 7'b0100011, 32'h10, 32'h11, M3,   M1);
        tbl[22] = v(1, 0,0,32'h0,32'h0,       1,1,32'h14,32'h22, 7'b0000000, 32'h10, 32'h0, M3,    M1);
        tbl[23] = v(1, 0,0,32'h0,32'h0,       1,1,32'h14,32'h22, 7'b0100011, 32'h14, 32'h22, M3,   M1);
        tbl[24] = v(1, 0,0,32'h0,32'h0,       1,1,32'h18,32'h33, 7'b0000000, 32'h14, 32'h0, M3,    M1);
        tbl[25] = v(1, 0,0,32'h0,32'h0,       1,1,32'h18,32'h33, 7'b0100011, 32'h18, 32'h33, M3,   M1);
        tbl[26] = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h18, 32'h0, M3,    M1);
        tbl[27] = v(1, 1,0,32'h10,32'h0,      1,0,32'h14,32'h0,  7'b0000000, 32'h18, 32'h0, M3,    M1);
        tbl[28] = v(1, 0,0,32'h0,32'h0,       1,0,32'h14,32'h0,  7'b1000101, 32'h10, 32'h0, M3,    M1);
        tbl[29] = v(1, 0,0,32'h0,32'h0,       1,0,32'h14,32'h0,  7'b0010001, 32'h10, 32'h0, 32'h11, M1);
        tbl[30] = v(1, 0,0,32'h0,32'h0,       1,0,32'h14,32'h0,  7'b0000000, 32'h10, 32'h0, 32'h11, M1);
        tbl[31] = v(1, 0,0,32'h0,32'h0,       1,0,32'h14,32'h0,  7'b0100101, 32'h14, 32'h0, 32'h11, M1);
        tbl[32] = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0001001, 32'h14, 32'h0, 32'h11, 32'h22);
        tbl[33] = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h14, 32'h0, 32'h11, 32'h22);
        tbl[34] = v(1, 1,0,32'h18,32'h0,      0,0,32'h0,32'h0,   7'b0000000, 32'h14, 32'h0, 32'h11, 32'h22);
        tbl[35] = v(1, 1,0,32'h18,32'h0,      0,0,32'h0,32'h0,   7'b1000101, 32'h18, 32'h0, 32'h11, 32'h22);
        tbl[36] = v(0, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000001, 32'h18, 32'h0, 32'h33, 32'h22);
        tbl[37] = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h0,  32'h0, 32'h0, 32'h0);
        tbl[38] = v(1, 0,0,32'h0,32'h0,       0,0,32'h0,32'h0,   7'b0000000, 32'h0,  32'h0, 32'h0, 32'h0);

        rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);

        // Directed table: inputs held for one cycle, outputs checked within it.
        for (int i = 0; i < NT; i++) begin
            @(posedge clk); #1;
            rst_n = tbl[i].rst_n;
            a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
            b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
            #1;
            check("tbl_flags", i, 64'({a_gnt, b_gnt, a_rvalid, b_rvalid, MemRead, MemWrite, busy}),
                  64'(tbl[i].e_flags));
            check("tbl_Address", i, 64'(Address), 64'(tbl[i].e_addr));
            if (tbl[i].e_flags[1]) check("tbl_WriteData", i, 64'(WriteData), 64'(tbl[i].e_wd));
            check("tbl_a_rdata", i, 64'(a_rdata), 64'(tbl[i].e_ard));
            check("tbl_b_rdata", i, 64'(b_rdata), 64'(tbl[i].e_brd));
        end

        check("mem_0x10", 0, 64'(mem[4]), 64'(32'h11));
        check("mem_0x14", 0, 64'(mem[5]), 64'(32'h22));
        check("mem_0x18", 0, 64'(mem[6]), 64'(32'h33));

        // Random phase: fresh memory image, reset, then reactive requesters.
        @(posedge clk); #1;
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]    = 32'h5000_0000 + 32'(i * 3);
            refmem[i] = 32'h5000_0000 + 32'(i * 3);
        end
        for (int i = 0; i <= NR + 3; i++) begin
            eg[i] = 0; erv[i] = 0; ewe[i] = 1'b0; ebusy[i] = 1'b0;
            eaddr[i] = '0; ewd[i] = '0; erd[i] = '0;
        end
        free_at = 0; prev_w = 2; last_addr = '0; last_wd = '0; exp_ard = '0; exp_brd = '0;
        @(posedge clk); #1;

        for (int c = 0; c < NR; c++) begin
            rst_n = 1'b1;
            if (eg[c] != 0) begin last_addr = eaddr[c]; last_wd = ewd[c]; end
            if (erv[c] == 1) exp_ard = erd[c];
            if (erv[c] == 2) exp_brd = erd[c];
            ef = {eg[c] == 1, eg[c] == 2, erv[c] == 1, erv[c] == 2,
                  eg[c] != 0 && !ewe[c], eg[c] != 0 && ewe[c], ebusy[c]};
            check("rnd_flags", c, 64'({a_gnt, b_gnt, a_rvalid, b_rvalid, MemRead, MemWrite, busy}), 64'(ef));
            check("rnd_Address", c, 64'(Address), 64'(last_addr));
            check("rnd_WriteData", c, 64'(WriteData), 64'(last_wd));
            check("rnd_a_rdata", c, 64'(a_rdata), 64'(exp_ard));
            check("rnd_b_rdata", c, 64'(b_rdata), 64'(exp_brd));

            // Requesters hold a transaction until the model says it was granted.
            if ((eg[c] == 1 && $urandom_range(0, 1) == 1) || (!a_req && $urandom_range(0, 2) == 0)) begin
                a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                a_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; a_wdata = $urandom;
            end else if (eg[c] == 1) a_req = 1'b0;
            if ((eg[c] == 2 && $urandom_range(0, 1) == 1) || (!b_req && $urandom_range(0, 2) == 0)) begin
                b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
                b_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; b_wdata = $urandom;
            end else if (eg[c] == 2) b_req = 1'b0;

            if (c >= free_at && (a_req || b_req)) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
                w = a_req ? 1 : 2;
`else
                if (a_req && b_req) w = (prev_w == 1) ? 2 : 1;
                else w = a_req ? 1 : 2;
`endif
                prev_w = w;
                twe = (w == 1) ? a_we : b_we;
                tad = (w == 1) ? a_addr : b_addr;
                twd = (w == 1) ? a_wdata : b_wdata;
                eg[c+1] = w; ewe[c+1] = twe; eaddr[c+1] = tad; ewd[c+1] = twd; ebusy[c+1] = 1'b1;
                if (twe) begin
                    refmem[tad[5:2]] = twd;
                    free_at = c + 2;
                end else begin
                    erv[c+2] = w; erd[c+2] = refmem[tad[5:2]]; ebusy[c+2] = 1'b1;
                    free_at = c + 3;
                end
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
